// File: rtl/ldpc_llr_packer_pkg.sv
// Shared definitions for the LDPC LLR packer: frame lengths per code rate,
// mode encodings and the framing FSM states.
package ldpc_llr_packer_pkg;

    localparam int NB_MODE1 = 32;
    localparam int NB_MODE2 = 24;
    localparam int BCNT_W   = 6;

    localparam logic [1:0] MODE_R23 = 2'd1;
    localparam logic [1:0] MODE_R78 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Index of the final output beat of a frame for the given mode.
    function automatic logic [BCNT_W-1:0] nb_last_for_mode(input logic [1:0] m);
        return (m == MODE_R78) ? BCNT_W'(NB_MODE2 - 1) : BCNT_W'(NB_MODE1 - 1);
    endfunction

endpackage

// File: rtl/ldpc_llr_sat.sv
// Combinational symmetric saturator: signed IN_W-bit LLR to signed VW-bit LLR,
// clamped to +/-(2^(VW-1)-1) so the most negative code is never produced.
module ldpc_llr_sat
    import ldpc_llr_packer_pkg::*;
#(
    parameter int IN_W = 12,
    parameter int VW   = 8
)
(
    input  logic [IN_W-1:0] llr_in,
    output logic [VW-1:0]   llr_out
);

    localparam int POS_MAX = 2**(VW-1) - 1;

    function automatic logic signed [VW-1:0] sat_sym(input logic signed [IN_W-1:0] x);
        logic signed [VW-1:0] y;
        if (int'(x) > POS_MAX)
            y = VW'(POS_MAX);
        else if (int'(x) < -POS_MAX)
            y = VW'(-POS_MAX);
        else
            y = x[VW-1:0];
        return y;
    endfunction

    logic signed [IN_W-1:0] llr_s;

    assign llr_s   = llr_in;
    assign llr_out = sat_sym(llr_s);

endmodule

// File: rtl/ldpc_llr_packer.sv
// Packs saturated demapper LLRs into ZC-wide decoder write beats and frames
// them per code rate, flagging short and overlong frames.
module ldpc_llr_packer
    import ldpc_llr_packer_pkg::*;
#(
    parameter int ZC    = 64,
    parameter int VW    = 8,
    parameter int IN_W  = 12,
    parameter int LANES = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [LANES*IN_W-1:0] s_data,
    output logic                  W_VALID,
    input  logic                  W_READY,
    output logic                  W_LAST,
    output logic [ZC*VW-1:0]      W_DATA,
    output logic                  err_len,
    input  logic                  err_clr,
    output logic [15:0]           frame_cnt
);

    localparam int GRP     = ZC / LANES;
    localparam int JW      = (GRP > 1) ? $clog2(GRP) : 1;
    localparam int SLICE_W = LANES * VW;

    state_t              state, state_nxt;

    logic [SLICE_W-1:0]  sat_p0;
    logic [ZC*VW-1:0]    acc_p0;
    logic                full_p0;
    logic                acc_last_p0;
    logic [JW-1:0]       jcnt;
    logic [BCNT_W-1:0]   bcnt;
    logic [BCNT_W-1:0]   nb_last;

    logic [ZC*VW-1:0]    data_p1;
    logic                vld_p1;
    logic                last_p1;

    logic                err_q;
    logic [15:0]         fcnt_q;

    logic                take;
    logic                grp_done;
    logic                bcnt_last;
    logic                frame_end;
    logic                out_fire;
    logic                load;
    logic                last_pending;
    logic                start_frame;

    for (genvar k = 0; k < LANES; k++) begin : g_sat
        ldpc_llr_sat #(
            .IN_W (IN_W),
            .VW   (VW)
        ) u_sat (
            .llr_in  (s_data[k*IN_W +: IN_W]),
            .llr_out (sat_p0[k*VW +: VW])
        );
    end

    // While full_p0 is set s_ready is low, so bcnt always names the group being filled.
    assign take         = (state == ST_FILL) && s_valid && !full_p0;
    assign grp_done     = (jcnt == JW'(GRP - 1));
    assign bcnt_last    = (bcnt == nb_last);
    assign frame_end    = grp_done && bcnt_last;
    assign out_fire     = vld_p1 && W_READY;
    assign load         = full_p0 && (!vld_p1 || W_READY);
    assign last_pending = (full_p0 && acc_last_p0) || (vld_p1 && last_p1);
    assign start_frame  = (state == ST_IDLE) && (state_nxt == ST_FILL);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((mode == MODE_R23 || mode == MODE_R78) && !last_pending)
                    state_nxt = ST_FILL;
            end
            ST_FILL: begin
                s_ready = !full_p0;
                if (take) begin
                    if (s_last)
                        state_nxt = ST_IDLE;
                    else if (frame_end)
                        state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                s_ready = 1'b1;
                if (s_valid && s_last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: lane accumulator; stage p1: single-entry output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            nb_last     <= '0;
            acc_p0      <= '0;
            full_p0     <= 1'b0;
            acc_last_p0 <= 1'b0;
            jcnt        <= '0;
            bcnt        <= '0;
            data_p1     <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            err_q       <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            if (start_frame)
                nb_last <= nb_last_for_mode(mode);

            if (load) begin
                data_p1     <= acc_p0;
                vld_p1      <= 1'b1;
                last_p1     <= acc_last_p0;
                full_p0     <= 1'b0;
                acc_p0      <= '0;
                acc_last_p0 <= 1'b0;
                bcnt        <= acc_last_p0 ? '0 : bcnt + 1'b1;
            end else if (out_fire) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end

            // Unwritten slots stay zero after the clear on load, which pads short groups.
            if (take) begin
                for (int j = 0; j < GRP; j++) begin
                    if (jcnt == JW'(j))
                        acc_p0[j*SLICE_W +: SLICE_W] <= sat_p0;
                end
                if (s_last || grp_done) begin
                    full_p0     <= 1'b1;
                    jcnt        <= '0;
                    acc_last_p0 <= s_last || bcnt_last;
                end else begin
                    jcnt <= jcnt + 1'b1;
                end
            end

            if (take && (s_last ^ frame_end))
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;

            if (out_fire && last_p1)
                fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign W_VALID   = vld_p1;
    assign W_LAST    = last_p1;
    assign W_DATA    = data_p1;
    assign err_len   = err_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_ldpc_llr_packer.sv
// Directed bench for ldpc_llr_packer: framing, saturation, stalls, length errors, reset.
module tb_ldpc_llr_packer;

    localparam int ZC    = 64;
    localparam int VW    = 8;
    localparam int IN_W  = 12;
    localparam int LANES = 8;
    localparam int GRP   = ZC / LANES;
    localparam int DW    = ZC * VW;
    localparam int SW    = LANES * IN_W;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic            s_valid;
    logic            s_ready;
    logic            s_last;
    logic [SW-1:0]   s_data;
    logic            W_VALID;
    logic            W_READY;
    logic            W_LAST;
    logic [DW-1:0]   W_DATA;
    logic            err_len;
    logic            err_clr;
    logic [15:0]     frame_cnt;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;
    int stall_seen = 0;
    int stall_bad = 0;
    int sready_drop = 0;
    logic sready_track = 1'b0;

    logic [SW-1:0] in_q[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] got_d[$];
    logic          exp_l[$];
    logic          got_l[$];

    ldpc_llr_packer #(
        .ZC    (ZC),
        .VW    (VW),
        .IN_W  (IN_W),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .s_data    (s_data),
        .W_VALID   (W_VALID),
        .W_READY   (W_READY),
        .W_LAST    (W_LAST),
        .W_DATA    (W_DATA),
        .err_len   (err_len),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        W_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       W_READY = 1'b1;
                1:       W_READY = ~W_READY;
                default: W_READY = 1'b0;
            endcase
        end
    end

    initial begin
        logic [DW-1:0] pd;
        logic          pl;
        logic          ps;
        ps = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ps = 1'b0;
            end else begin
                if (ps) begin
                    stall_seen++;
                    if (!W_VALID || W_DATA !== pd || W_LAST !== pl)
                        stall_bad++;
                end
                if (W_VALID && W_READY) begin
                    got_d.push_back(W_DATA);
                    got_l.push_back(W_LAST);
                end
                if (sready_track && s_valid && !s_ready)
                    sready_drop++;
                ps = W_VALID && !W_READY;
                pd = W_DATA;
                pl = W_LAST;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout time=%0t limit=600000", $time);
        $fatal(1);
    end

    function automatic logic [VW-1:0] sat_ref(input int v);
        if (v > 127)
            return 8'h7F;
        if (v < -127)
            return 8'h81;
        return VW'(v);
    endfunction

    task automatic fill_ramp(input int n, input int base);
        logic [SW-1:0] w;
        int v;
        in_q.delete();
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < LANES; k++) begin
                v = b * LANES + k + base;
                w[k*IN_W +: IN_W] = v[IN_W-1:0];
            end
            in_q.push_back(w);
        end
    endtask

    task automatic build_expected(input int nb, input int last_idx);
        logic [DW-1:0] d;
        logic          l;
        int            idx;
        int            v;
        exp_d.delete();
        exp_l.delete();
        for (int g = 0; g < nb; g++) begin
            d = '0;
            l = (g == nb - 1);
            for (int j = 0; j < GRP; j++) begin
                idx = g * GRP + j;
                if (idx < in_q.size() && (last_idx < 0 || idx <= last_idx)) begin
                    for (int k = 0; k < LANES; k++) begin
                        v = $signed(in_q[idx][k*IN_W +: IN_W]);
                        d[(j*LANES+k)*VW +: VW] = sat_ref(v);
                    end
                    if (idx == last_idx)
                        l = 1'b1;
                end
            end
            exp_d.push_back(d);
            exp_l.push_back(l);
            if (l)
                break;
        end
    endtask

    task automatic drive_beat(input logic [SW-1:0] d, input logic last);
        int c;
        c = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (!s_ready) begin
            bad++;
            $display("FAIL beat_accept_timeout s_ready=%0b required=1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_idx, input logic [1:0] m);
        mode = m;
        sready_track = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_beat(in_q[i], i == last_idx);
            if (i == 0) begin
                mode = 2'd0;
                sready_track = 1'b1;
            end
        end
        sready_track = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int c;
        c = 0;
        while (got_d.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%0b exp=0", s_ready); end
        total++;
        if (W_VALID !== 1'b0) begin bad++; $display("FAIL reset_w_valid got=%0b exp=0", W_VALID); end
        total++;
        if (W_LAST !== 1'b0) begin bad++; $display("FAIL reset_w_last got=%0b exp=0", W_LAST); end
        total++;
        if (W_DATA !== '0) begin bad++; $display("FAIL reset_w_data got=%0h exp=0", W_DATA); end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL reset_err_len got=%0b exp=0", err_len); end
        total++;
        if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_mode1_full();
        rdy_mode = 0;
        got_d.delete();
        got_l.delete();
        fill_ramp(256, -1000);
        build_expected(32, 255);
        send_frame(256, 255, 2'd1);
        wait_outputs(32);
        total++;
        if (got_d.size() !== 32) begin bad++; $display("FAIL m1_beat_count got=%0d exp=32", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL m1_beat%0d last=%0b exp_last=%0b data_lo=%0h exp_lo=%0h", i, got_l[i], exp_l[i], got_d[i][63:0], exp_d[i][63:0]);
            end
        end
        total++;
        if (got_l[31] !== 1'b1 || got_l[30] !== 1'b0) begin bad++; $display("FAIL m1_last_pos l30=%0b l31=%0b exp=0,1", got_l[30], got_l[31]); end
        total++;
        if (got_d[0][7:0] !== 8'h81) begin bad++; $display("FAIL m1_llr0_clamp got=%0h exp=81", got_d[0][7:0]); end
        total++;
        if (got_d[15][45*VW +: VW] !== 8'h05) begin bad++; $display("FAIL m1_pass_pos got=%0h exp=05", got_d[15][45*VW +: VW]); end
        total++;
        if (got_d[15][37*VW +: VW] !== 8'hFD) begin bad++; $display("FAIL m1_pass_neg got=%0h exp=fd", got_d[15][37*VW +: VW]); end
        total++;
        if (got_d[31][63*VW +: VW] !== 8'h7F) begin bad++; $display("FAIL m1_top_clamp got=%0h exp=7f", got_d[31][63*VW +: VW]); end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL m1_err_len got=%0b exp=0", err_len); end
        total++;
        if (frame_cnt !== 16'd1) begin bad++; $display("FAIL m1_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_mode2_stall();
        rdy_mode = 1;
        stall_seen = 0;
        stall_bad = 0;
        sready_drop = 0;
        got_d.delete();
        got_l.delete();
        fill_ramp(192, -700);
        build_expected(24, 191);
        send_frame(192, 191, 2'd2);
        wait_outputs(24);
        rdy_mode = 0;
        total++;
        if (got_d.size() !== 24) begin bad++; $display("FAIL m2_beat_count got=%0d exp=24", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL m2_beat%0d last=%0b exp_last=%0b data_lo=%0h exp_lo=%0h", i, got_l[i], exp_l[i], got_d[i][63:0], exp_d[i][63:0]);
            end
        end
        total++;
        if (got_d[10][61*VW +: VW] !== 8'h01) begin bad++; $display("FAIL m2_pass_llr got=%0h exp=01", got_d[10][61*VW +: VW]); end
        total++;
        if (stall_bad !== 0) begin bad++; $display("FAIL m2_stall_stable unstable=%0d exp=0", stall_bad); end
        total++;
        if (stall_seen == 0) begin bad++; $display("FAIL m2_stall_seen got=%0d exp>0", stall_seen); end
        total++;
        if (sready_drop == 0) begin bad++; $display("FAIL m2_sready_drop got=%0d exp>0", sready_drop); end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL m2_err_len got=%0b exp=0", err_len); end
        total++;
        if (frame_cnt !== 16'd2) begin bad++; $display("FAIL m2_frame_cnt got=%0d exp=2", frame_cnt); end
    endtask

    task automatic test_early_last();
        logic [DW-1:0] tmp;
        rdy_mode = 0;
        got_d.delete();
        got_l.delete();
        fill_ramp(84, -600);
        build_expected(32, 83);
        send_frame(84, 83, 2'd1);
        wait_outputs(11);
        total++;
        if (got_d.size() !== 11) begin bad++; $display("FAIL early_beat_count got=%0d exp=11", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL early_beat%0d last=%0b exp_last=%0b data_lo=%0h exp_lo=%0h", i, got_l[i], exp_l[i], got_d[i][63:0], exp_d[i][63:0]);
            end
        end
        tmp = got_d[10];
        total++;
        if (tmp[DW-1:32*VW] !== '0) begin bad++; $display("FAIL early_zero_pad got=%0h exp=0", tmp[DW-1:32*VW]); end
        total++;
        if (tmp[31*VW +: VW] !== 8'h47) begin bad++; $display("FAIL early_llr31 got=%0h exp=47", tmp[31*VW +: VW]); end
        total++;
        if (got_l[10] !== 1'b1) begin bad++; $display("FAIL early_w_last got=%0b exp=1", got_l[10]); end
        total++;
        if (err_len !== 1'b1) begin bad++; $display("FAIL early_err_len got=%0b exp=1", err_len); end
        total++;
        if (frame_cnt !== 16'd3) begin bad++; $display("FAIL early_frame_cnt got=%0d exp=3", frame_cnt); end
    endtask

    task automatic test_saturation();
        logic [SW-1:0] w;
        rdy_mode = 0;
        got_d.delete();
        got_l.delete();
        fill_ramp(192, -700);
        w = {12'hFFF, 12'h000, 12'h800, 12'h7FF, 12'hF80, 12'hF81, 12'h080, 12'h07F};
        in_q[0] = w;
        build_expected(24, 191);
        send_frame(192, 191, 2'd2);
        wait_outputs(24);
        total++;
        if (got_d.size() !== 24) begin bad++; $display("FAIL sat_beat_count got=%0d exp=24", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL sat_beat%0d last=%0b exp_last=%0b data_lo=%0h exp_lo=%0h", i, got_l[i], exp_l[i], got_d[i][63:0], exp_d[i][63:0]);
            end
        end
        total++;
        if (got_d[0][63:0] !== 64'hFF00_817F_8181_7F7F) begin bad++; $display("FAIL sat_bounds got=%0h exp=ff00817f81817f7f", got_d[0][63:0]); end
        total++;
        if (err_len !== 1'b1) begin bad++; $display("FAIL sat_err_sticky got=%0b exp=1", err_len); end
        total++;
        if (frame_cnt !== 16'd4) begin bad++; $display("FAIL sat_frame_cnt got=%0d exp=4", frame_cnt); end
    endtask

    task automatic test_overlong();
        rdy_mode = 0;
        got_d.delete();
        got_l.delete();
        fill_ramp(200, -800);
        build_expected(24, 199);
        send_frame(200, 199, 2'd2);
        wait_outputs(24);
        total++;
        if (got_d.size() !== 24) begin bad++; $display("FAIL long_beat_count got=%0d exp=24", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL long_beat%0d last=%0b exp_last=%0b data_lo=%0h exp_lo=%0h", i, got_l[i], exp_l[i], got_d[i][63:0], exp_d[i][63:0]);
            end
        end
        total++;
        if (err_len !== 1'b1) begin bad++; $display("FAIL long_err_len got=%0b exp=1", err_len); end
        total++;
        if (frame_cnt !== 16'd5) begin bad++; $display("FAIL long_frame_cnt got=%0d exp=5", frame_cnt); end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL long_err_clr got=%0b exp=0", err_len); end
    endtask

    task automatic test_reset_mid_frame();
        rdy_mode = 0;
        fill_ramp(50, -1000);
        send_frame(50, -1, 2'd1);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        total++;
        if (W_VALID !== 1'b0 || W_LAST !== 1'b0) begin bad++; $display("FAIL rmid_w_ctrl valid=%0b last=%0b exp=0,0", W_VALID, W_LAST); end
        total++;
        if (W_DATA !== '0) begin bad++; $display("FAIL rmid_w_data got=%0h exp=0", W_DATA); end
        total++;
        if (frame_cnt !== 16'd0 || err_len !== 1'b0) begin bad++; $display("FAIL rmid_status frame_cnt=%0d err_len=%0b exp=0,0", frame_cnt, err_len); end
        mode = 2'd0;
        s_valid = 1'b1;
        s_data = in_q[0];
        repeat (5) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0 || W_VALID !== 1'b0) begin bad++; $display("FAIL rmid_mode0_stall s_ready=%0b w_valid=%0b exp=0,0", s_ready, W_VALID); end
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        got_d.delete();
        got_l.delete();
        fill_ramp(256, -1000);
        build_expected(32, 255);
        send_frame(256, 255, 2'd1);
        wait_outputs(32);
        total++;
        if (got_d.size() !== 32) begin bad++; $display("FAIL rmid_beat_count got=%0d exp=32", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL rmid_beat%0d last=%0b exp_last=%0b data_lo=%0h exp_lo=%0h", i, got_l[i], exp_l[i], got_d[i][63:0], exp_d[i][63:0]);
            end
        end
        total++;
        if (got_d[0][7:0] !== 8'h81 || got_d[15][45*VW +: VW] !== 8'h05) begin
            bad++;
            $display("FAIL rmid_pack_origin llr0=%0h llr_b15_45=%0h exp=81,05", got_d[0][7:0], got_d[15][45*VW +: VW]);
        end
        total++;
        if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rmid_frame_cnt got=%0d exp=1", frame_cnt); end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL rmid_err_len got=%0b exp=0", err_len); end
    endtask

    initial begin
        rst     = 1'b1;
        mode    = 2'd0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_mode1_full();
        test_mode2_stall();
        test_early_last();
        test_saturation();
        test_overlong();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
